// File: rtl/pix10_pkg.sv
// Shared defaults and pointer type for the pix10 FIFO controller.
package pix10_pkg;

  localparam int unsigned DATA_W_DEF = 10;
  localparam int unsigned ADDR_W_DEF = 2;

  // The extra MSB is the wrap bit that tells full apart from empty.
  typedef logic [ADDR_W_DEF:0] ptr_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer counter: async reset, sync clear, increment enable.
module fifo_ptr #(
  parameter int unsigned W = 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CLR,
  input  logic         INC,
  output logic [W-1:0] PTR
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (CLR) begin
      ptr_d = '0;
    end else if (INC) begin
      ptr_d = ptr_q + W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign PTR = ptr_q;

endmodule

// File: rtl/pix10_fifo_ctrl.sv
// FIFO controller for external storage. Define PIX10_FIFO_STATUS_EN to add
// the LEVEL and ALMOST_FULL status outputs.
module pix10_fifo_ctrl
  import pix10_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FLUSH,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              WE,
  output logic [ADDR_W-1:0] WADDR,
  output logic [DATA_W-1:0] WDATAIN,
  output logic [ADDR_W-1:0] RADDR,
  input  logic [DATA_W-1:0] RDATAOUT
`ifdef PIX10_FIFO_STATUS_EN
  ,
  output logic [ADDR_W:0]   LEVEL,
  output logic              ALMOST_FULL
`endif
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [ADDR_W:0] wptr, rptr;
  logic            full, empty, push, pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && (wptr[ADDR_W] != rptr[ADDR_W]);

  // Pointers sit at 0 during reset, so ready must be masked explicitly.
  assign IN_READY  = !full && !FLUSH && !RST;
  assign OUT_VALID = !empty && !FLUSH && !RST;

  assign push = IN_VALID && IN_READY;
  assign pop  = OUT_VALID && OUT_READY;

  assign WE       = push;
  assign WADDR    = wptr[ADDR_W-1:0];
  assign WDATAIN  = IN_DATA;
  assign RADDR    = rptr[ADDR_W-1:0];
  assign OUT_DATA = RDATAOUT;

  fifo_ptr #(
    .W(ADDR_W + 1)
  ) u_wptr (
    .CLK(CLK),
    .RST(RST),
    .CLR(FLUSH),
    .INC(push),
    .PTR(wptr)
  );

  fifo_ptr #(
    .W(ADDR_W + 1)
  ) u_rptr (
    .CLK(CLK),
    .RST(RST),
    .CLR(FLUSH),
    .INC(pop),
    .PTR(rptr)
  );

`ifdef PIX10_FIFO_STATUS_EN
  // Modular difference of the wrap-bit pointers gives 0..Depth directly.
  assign LEVEL       = wptr - rptr;
  assign ALMOST_FULL = 32'(LEVEL) >= (Depth - 1);
`endif

endmodule

// File: tb/tb_pix10_fifo_ctrl.sv
// Self-checking bench for pix10_fifo_ctrl: directed vectors, corner sequences
// and a randomized run against a queue-based reference model.
module tb_pix10_fifo_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       FLUSH;
  logic [9:0] IN_DATA;
  logic       IN_VALID;
  logic       IN_READY;
  logic [9:0] OUT_DATA;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic       WE;
  logic [1:0] WADDR;
  logic [9:0] WDATAIN;
  logic [1:0] RADDR;
  logic [9:0] RDATAOUT;
`ifdef PIX10_FIFO_STATUS_EN
  logic [2:0] LEVEL;
  logic       ALMOST_FULL;
`endif

  int nchk = 0;
  int nerr = 0;

  always #5 CLK = ~CLK;

  pix10_fifo_ctrl #(
    .DATA_W(10),
    .ADDR_W(2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .FLUSH(FLUSH),
    .IN_DATA(IN_DATA),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .OUT_DATA(OUT_DATA),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .WE(WE),
    .WADDR(WADDR),
    .WDATAIN(WDATAIN),
    .RADDR(RADDR),
    .RDATAOUT(RDATAOUT)
`ifdef PIX10_FIFO_STATUS_EN
    ,
    .LEVEL(LEVEL),
    .ALMOST_FULL(ALMOST_FULL)
`endif
  );

  // External storage: synchronous write, combinational read.
  logic [9:0] mem [4];
  always @(posedge CLK) if (WE) mem[WADDR] <= WDATAIN;
  assign RDATAOUT = mem[RADDR];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [9:0] d, input logic ordy);
    FLUSH     = fl;
    IN_VALID  = iv;
    IN_DATA   = d;
    OUT_READY = ordy;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic       fl;
    logic       iv;
    logic [9:0] din;
    logic       ordy;
    logic       eir;
    logic       eov;
    logic       ewe;
    logic [1:0] ewa;
    logic [1:0] era;
    logic [9:0] eod;
  } vec_t;

  vec_t vecs[11];

  // Reference model state
  int unsigned q[$];
  int unsigned wcnt, rcnt;

  initial begin
    int unsigned got[$];
    drive(1'b0, 1'b1, 10'h3FF, 1'b0);
    RST = 1'b1;
    #12;
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_we", WE, 0);
    chk("rst_waddr", WADDR, 0);
    chk("rst_raddr", RADDR, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    //            fl    iv    din      ordy  eir   eov   ewe   ewa    era    eod
    vecs[0]  = '{1'b0, 1'b1, 10'h3FF, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 10'h000};
    vecs[1]  = '{1'b0, 1'b1, 10'h001, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 2'd0, 10'h3FF};
    vecs[2]  = '{1'b0, 1'b1, 10'h2AA, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 2'd0, 10'h3FF};
    vecs[3]  = '{1'b0, 1'b1, 10'h155, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 2'd0, 10'h3FF};
    vecs[4]  = '{1'b0, 1'b1, 10'h0AB, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 10'h3FF};
    vecs[5]  = '{1'b0, 1'b1, 10'h0AB, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd1, 10'h001};
    vecs[6]  = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 10'h000};
    vecs[7]  = '{1'b0, 1'b1, 10'h05A, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 10'h000};
    vecs[8]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 2'd0, 10'h05A};
    vecs[9]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 10'h000};
    vecs[10] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 10'h000};

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].din, vecs[i].ordy);
      @(negedge CLK);
      chk($sformatf("v%0d_in_ready", i), IN_READY, vecs[i].eir);
      chk($sformatf("v%0d_out_valid", i), OUT_VALID, vecs[i].eov);
      chk($sformatf("v%0d_we", i), WE, vecs[i].ewe);
      chk($sformatf("v%0d_waddr", i), WADDR, vecs[i].ewa);
      chk($sformatf("v%0d_raddr", i), RADDR, vecs[i].era);
      if (vecs[i].eov) chk($sformatf("v%0d_out_data", i), OUT_DATA, vecs[i].eod);
`ifdef PIX10_FIFO_STATUS_EN
      if (i == 6) chk("flush_level_before", LEVEL, 4);
      if (i == 7) chk("flush_level_after", LEVEL, 0);
`endif
      next_cycle();
    end

    // Asynchronous reset mid-cycle with three words queued.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 10'(i + 10'h100), 1'b0);
      next_cycle();
    end
    drive(1'b0, 1'b0, 10'h000, 1'b0);
    #2;
    chk("pre_rst_out_valid", OUT_VALID, 1);
    RST = 1'b1;
    #1;
    chk("arst_out_valid", OUT_VALID, 0);
    chk("arst_in_ready", IN_READY, 0);
    chk("arst_waddr", WADDR, 0);
    chk("arst_raddr", RADDR, 0);
`ifdef PIX10_FIFO_STATUS_EN
    chk("arst_level", LEVEL, 0);
    chk("arst_almost_full", ALMOST_FULL, 0);
`endif
    next_cycle();
    RST = 1'b0;
    drive(1'b0, 1'b1, 10'h111, 1'b0);
    @(negedge CLK);
    chk("post_rst_waddr", WADDR, 0);
    chk("post_rst_we", WE, 1);
    next_cycle();
    drive(1'b0, 1'b0, 10'h000, 1'b1);
    @(negedge CLK);
    chk("post_rst_out_valid", OUT_VALID, 1);
    chk("post_rst_out_data", OUT_DATA, 10'h111);
    next_cycle();

    // Streaming: push 0..19 while popping continuously.
    for (int i = 0; i <= 20; i++) begin
      drive(1'b0, i < 20, 10'(i), 1'b1);
      @(negedge CLK);
      if (OUT_VALID) got.push_back(int'(OUT_DATA));
      next_cycle();
    end
    chk("stream_count", got.size(), 20);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("stream_word%0d", i), (i < got.size()) ? got[i] : -1, i);
    end

    // Randomized run against the queue model; start from a flush.
    q.delete();
    wcnt = 0;
    rcnt = 0;
    for (int i = 0; i < 400; i++) begin
      logic fl, iv, ordy, e_ir, e_ov;
      logic [9:0] d;
      fl   = (i == 0) || ($urandom_range(15) == 0);
      iv   = $urandom_range(2) != 0;
      ordy = $urandom_range(2) != 0;
      d    = 10'($urandom);
      drive(fl, iv, d, ordy);
      e_ir = (q.size() < 4) && !fl;
      e_ov = (q.size() > 0) && !fl;
      @(negedge CLK);
      if (i > 0) begin
        chk("rnd_in_ready", IN_READY, e_ir);
        chk("rnd_out_valid", OUT_VALID, e_ov);
        chk("rnd_we", WE, iv && e_ir);
        chk("rnd_waddr", WADDR, wcnt % 4);
        chk("rnd_raddr", RADDR, rcnt % 4);
        if (e_ov) chk("rnd_out_data", OUT_DATA, q[0]);
`ifdef PIX10_FIFO_STATUS_EN
        chk("rnd_level", LEVEL, q.size());
        chk("rnd_almost_full", ALMOST_FULL, q.size() >= 3);
`endif
      end
      if (fl) begin
        q.delete();
        wcnt = 0;
        rcnt = 0;
      end else begin
        if (e_ov && ordy) begin
          void'(q.pop_front());
          rcnt++;
        end
        if (iv && e_ir) begin
          q.push_back(d);
          wcnt++;
        end
      end
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/pix10_fifo_ctrl.md
PIX10_FIFO_CTRL -- requirements
Module: pix10_fifo_ctrl

Interface
REQ-001 Parameter: DATA_W, default 10, payload width in bits.
REQ-002 Parameter: ADDR_W, default 2, storage address width; depth = 2**ADDR_W (4 entries by default).
REQ-003 Port: CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: RST  in  1  asynchronous active-high reset.
REQ-005 Port: FLUSH  in  1  synchronous clear of contents; pointers return to 0.
REQ-006 Port: IN_DATA  in  DATA_W  upstream pixel word.
REQ-007 Port: IN_VALID  in  1  upstream word present.
REQ-008 Port: IN_READY  out  1  block accepts a word this cycle.
REQ-009 Port: OUT_DATA  out  DATA_W  head-of-queue word.
REQ-010 Port: OUT_VALID  out  1  head word valid.
REQ-011 Port: OUT_READY  in  1  downstream consumes the head word this cycle.
REQ-012 Port: WE  out  1  storage write enable.
REQ-013 Port: WADDR  out  ADDR_W  storage write address.
REQ-014 Port: WDATAIN  out  DATA_W  storage write data.
REQ-015 Port: RADDR  out  ADDR_W  storage read address.
REQ-016 Port: RDATAOUT  in  DATA_W  storage read data, combinational from RADDR.

Function
REQ-017 push = IN_VALID & IN_READY; pop = OUT_VALID & OUT_READY; FLUSH overrides both and clears the queue.
REQ-018 Write and read pointers are ADDR_W+1 bits; address = low ADDR_W bits; the MSB is the wrap bit.
REQ-019 Empty when pointers are equal; full when low bits match and MSBs differ.
REQ-020 IN_READY = !full & !FLUSH; OUT_VALID = !empty & !FLUSH; both combinational from registered pointers only.
REQ-021 WE = push; WADDR = wptr low bits; WDATAIN = IN_DATA; RADDR = rptr low bits; OUT_DATA = RDATAOUT.
REQ-022 On push, wptr increments by 1 modulo 2**(ADDR_W+1); on pop, rptr increments likewise; pointer wrap from all-ones to 0 is seamless.
REQ-023 Latency: a word pushed into an empty queue appears at OUT_VALID=1 on the next cycle; no same-cycle bypass.
REQ-024 Simultaneous push and pop with the queue neither empty nor full: both proceed; occupancy unchanged.
REQ-025 When full, IN_READY=0 even when pop occurs in the same cycle; IN_READY returns to 1 on the cycle after the pop.
REQ-026 When empty, pop cannot occur; an OUT_READY pulse while empty has no effect.
REQ-027 Words leave in strict arrival order; no word is duplicated or lost while RST and FLUSH are low.

Reset
REQ-028 RST asserted clears both pointers to 0 immediately, regardless of CLK.
REQ-029 While RST is high: IN_READY=0, OUT_VALID=0, WE=0, WADDR=0, RADDR=0.
REQ-030 RST asserted mid-transfer discards all queued words; after release, the first accepted word is written to address 0.
REQ-031 Storage contents are not cleared; OUT_DATA is don't-care while OUT_VALID=0.

Configuration
REQ-032 Macro PIX10_FIFO_STATUS_EN: when defined, adds LEVEL out ADDR_W+1 (occupancy 0..depth, = wptr-rptr) and ALMOST_FULL out 1 (LEVEL >= depth-1); both reset to 0 and clear on FLUSH.
REQ-033 When undefined, these ports and their logic are absent; all other behaviour is identical.

Structure
REQ-034 Shared package pix10_pkg holds the DATA_W/ADDR_W defaults and the pointer typedef (ADDR_W+1 bits).
REQ-035 One sub-module, fifo_ptr: wrapping pointer counter with increment enable, sync clear, and async reset; instantiated twice (write and read).
REQ-036 Storage is external; the block drives only its write/read ports.

Verification
REQ-037 Reset release, push 0x3FF, 0x001, 0x2AA with OUT_READY=0 -> WADDR 0,1,2; OUT_VALID=1 from cycle after the first push; OUT_DATA=0x3FF.
REQ-038 Push 4 words, IN_VALID held -> IN_READY=0 after the 4th; one pop -> IN_READY=1 next cycle; 5th word written at WADDR=0.
REQ-039 Continuous push and pop for 20 cycles, data 0..19 -> output sequence 0..19 exactly; pointers wrap at least twice; occupancy constant.
REQ-040 Full queue with simultaneous IN_VALID=1 and OUT_READY=1 -> pop only; WE=0 that cycle.
REQ-041 2 words queued, FLUSH for 1 cycle -> OUT_VALID=0 next cycle; next push lands at WADDR=0; with PIX10_FIFO_STATUS_EN, LEVEL 2->0.
REQ-042 RST pulse asynchronously mid-cycle with 3 words queued -> OUT_VALID and IN_READY drop without a clock edge; with PIX10_FIFO_STATUS_EN, LEVEL=0 and ALMOST_FULL=0.
